booth_mult_seq: RTL

Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's 8-bit Booth multiplier and adds:
- a generic operand width;
- a per-operation signed/unsigned mode;
- a valid/ready handshake on both the input and output sides.
It sits between an operand producer (e.g. the datapath controller) and a result consumer, and performs one add/sub-plus-shift step per clock.

---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_step.sv | 37 +++
 rtl/booth_mult_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//
// Contents:
//   booth_state_t : FSM state encoding (IDLE, CALC, DONE), 2 bits
//   EXT_MAX       : widest extended operand the helper supports (32 + 1 bits)
//   ext()         : sign- or zero-extends a 'width'-bit value to EXT_MAX bits
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_t;

  localparam int EXT_MAX = 33;

  // The caller zero-fills 'value' above bit width-1. Every bit from position
  // 'width' upwards becomes a copy of the operand sign bit in signed mode, or
  // zero in unsigned mode. The result is always one bit wider than any legal
  // operand. As a result, an extended multiplicand can never be the most-negative
  // value of the internal width, and ACC cannot overflow.
  function automatic logic [EXT_MAX-1:0] ext(input logic [EXT_MAX-2:0] value,
                                             input logic               is_signed,
                                             input int                 width);
    logic [EXT_MAX-1:0] r;
    logic               s;
    s = is_signed & value[width-1];
    r = {1'b0, value};
    for (int i = 0; i < EXT_MAX; i++) begin
      if (i >= width) r[i] = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration.
//
// Parameters:
//   W1       : internal register width (operand width + 1)
// Ports:
//   acc, q, q_1                     : current partial product / multiplier state
//   m                               : extended multiplicand
//   acc_next, q_next, q_1_next      : state after add/sub and arithmetic shift
module booth_step #(
  parameter int W1 = 9
) (
  input  logic [W1-1:0] acc,
  input  logic [W1-1:0] q,
  input  logic          q_1,
  input  logic [W1-1:0] m,
  output logic [W1-1:0] acc_next,
  output logic [W1-1:0] q_next,
  output logic          q_1_next
);

  logic [W1-1:0] sum;

  // Booth recoding of {q[0], q_1} selects +M, -M or nothing. The arithmetic
  // right shift of {sum, q, q_1} follows in the same cycle.
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next = {sum[W1-1], sum[W1-1:1]};
    q_next   = {sum[0], q[W1-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a generic operand width, a
// per-operation signed/unsigned mode, and valid/ready handshakes on both sides.
// Each CALC cycle performs one add/sub-plus-shift step.
//
// Parameters:
//   WIDTH     : operand width, 2..32
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands and mode present
//   in_ready  : block can accept operands (IDLE only)
//   A, B      : multiplicand, multiplier
//   is_signed : 1 = two's complement, 0 = unsigned; sampled at accept
//   out_valid : Mult is valid and held (DONE)
//   out_ready : consumer takes Mult
//   Mult      : 2*WIDTH-bit product, registered, holds its last value
//   busy      : high in CALC and DONE
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Mult,
  output logic               busy
);

  localparam int ITER  = WIDTH + 1;
  localparam int W1    = WIDTH + 1;
  localparam int CNT_W = $clog2(ITER) + 1;

  booth_state_t state, next_state;

  logic [W1-1:0]    m, acc, q;
  logic             q_1;
  logic [CNT_W-1:0] cnt;
  logic [W1-1:0]    acc_n, q_n;
  logic             q_1_n;
  logic [W1-1:0]    m_init, q_init;
  logic             load, step_en;

  // Operands are extended at accept time. Later changes on A, B and is_signed
  // therefore cannot affect an operation that is already in flight.
  assign m_init = W1'(ext(32'(A), is_signed, WIDTH));
  assign q_init = W1'(ext(32'(B), is_signed, WIDTH));

  booth_step #(.W1(W1)) u_step (
    .acc      (acc),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .acc_next (acc_n),
    .q_next   (q_n),
    .q_1_next (q_1_n)
  );

  // State register. Reset returns to IDLE immediately. The handshake outputs
  // are decoded from the state, so they reach their reset values asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake decoding. Requests that arrive in the wrong state
  // (in_valid while busy, or out_ready outside DONE) fall through unused.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    step_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        busy    = 1'b1;
        step_en = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. In the final step (cnt == 0), the product is captured
  // directly from the step outputs. It is the low 2*WIDTH bits of
  // {acc_n, q_n}, which means the low WIDTH-1 bits of acc_n on top of q_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m    <= '0;
      acc  <= '0;
      q    <= '0;
      q_1  <= 1'b0;
      cnt  <= '0;
      Mult <= '0;
    end else if (load) begin
      m    <= m_init;
      q    <= q_init;
      acc  <= '0;
      q_1  <= 1'b0;
      cnt  <= CNT_W'(ITER - 1);
    end else if (step_en) begin
      acc  <= acc_n;
      q    <= q_n;
      q_1  <= q_1_n;
      if (cnt != '0) cnt  <= cnt - CNT_W'(1);
      else           Mult <= {acc_n[WIDTH-2:0], q_n};
    end
  end

endmodule
